// File: rtl/fu_pkg.sv
// Shared types and field map for the integer execute unit.
// Covers the issued-entry bit layout, the ALU micro-op codes and the pipeline stage payload.
package fu_pkg;

   localparam int unsigned ENTRY_SIZE = 129;
   localparam int unsigned PREG_W     = 6;
   localparam int unsigned ROB_W      = 6;
   localparam int unsigned XLEN       = 32;
   localparam int unsigned OPC_W      = 7;

   // Issued-entry field positions (LSB of each field)
   localparam int unsigned ROB_LSB      = 0;
   localparam int unsigned IMM_LSB      = 6;
   localparam int unsigned OPC_LSB      = 38;
   localparam int unsigned RS2_VAL_LSB  = 45;
   localparam int unsigned PHYS_RS2_LSB = 77;
   localparam int unsigned RS1_VAL_LSB  = 83;
   localparam int unsigned PHYS_RS1_LSB = 115;
   localparam int unsigned PHYS_RD_LSB  = 121;
   localparam int unsigned RS1_RDY_BIT  = 127;
   localparam int unsigned RS2_RDY_BIT  = 128;

   localparam int unsigned OPC_IMM_BIT  = 6;
   localparam int unsigned OPC_NOWB_BIT = 5;

   typedef enum logic [3:0] {
      OP_ADD   = 4'd0,
      OP_SUB   = 4'd1,
      OP_AND   = 4'd2,
      OP_OR    = 4'd3,
      OP_XOR   = 4'd4,
      OP_SLL   = 4'd5,
      OP_SRL   = 4'd6,
      OP_SRA   = 4'd7,
      OP_SLT   = 4'd8,
      OP_SLTU  = 4'd9,
      OP_PASSB = 4'd10
   } alu_op_e;

   typedef struct packed {
      logic [PREG_W-1:0] rd;
      logic [XLEN-1:0]   val;
      logic [ROB_W-1:0]  rob_idx;
      logic              wb_en;
   } stage_pl_t;

endpackage

// File: rtl/fu_exec_pipe_if.sv
// Issue-port and forwarding/writeback bus between the issue queue and one execute unit.
interface fu_exec_pipe_if;
   import fu_pkg::*;

   logic                  issue_enable;
   logic [ENTRY_SIZE-1:0] issue_entry;
   logic                  fu_ready;
   logic                  flush;
   logic                  wb_ready;
   logic                  fwd_valid;
   logic [PREG_W-1:0]     fwd_rd;
   logic [XLEN-1:0]       fwd_val;
   logic [ROB_W-1:0]      fwd_rob_idx;
   logic                  fwd_wb_en;
   logic                  err_sticky;

   modport master (
      output issue_enable, issue_entry, flush, wb_ready,
      input  fu_ready, fwd_valid, fwd_rd, fwd_val, fwd_rob_idx, fwd_wb_en, err_sticky
   );

   modport slave (
      input  issue_enable, issue_entry, flush, wb_ready,
      output fu_ready, fwd_valid, fwd_rd, fwd_val, fwd_rob_idx, fwd_wb_en, err_sticky
   );

endinterface

// File: rtl/fu_alu.sv
// Combinational integer ALU: one micro-op on two 32-bit operands.
// Codes outside the defined set return 0 and raise illegal_c.
module fu_alu
   import fu_pkg::*;
(
   input  alu_op_e         op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic [XLEN-1:0] result_c,
   output logic            illegal_c
);

   logic [4:0] shamt_c;

   assign shamt_c = b[4:0];

   always_comb begin
      result_c  = '0;
      illegal_c = 1'b0;
      case (op)
         OP_ADD:   result_c = a + b;
         OP_SUB:   result_c = a - b;
         OP_AND:   result_c = a & b;
         OP_OR:    result_c = a | b;
         OP_XOR:   result_c = a ^ b;
         OP_SLL:   result_c = a << shamt_c;
         OP_SRL:   result_c = a >> shamt_c;
         OP_SRA:   result_c = XLEN'($signed(a) >>> shamt_c);
         OP_SLT:   result_c = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_SLTU:  result_c = {{(XLEN-1){1'b0}}, (a < b)};
         OP_PASSB: result_c = b;
         default: begin
            result_c  = '0;
            illegal_c = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/fu_exec_pipe.sv
// Fixed-latency integer execute pipeline: ALU at issue, LATENCY payload stages, then a
// registered forwarding/writeback output that freezes the whole pipe under back-pressure.
module fu_exec_pipe
   import fu_pkg::*;
#(
   parameter int unsigned LATENCY = 2
) (
   input  logic          clk,
   input  logic          reset,
   fu_exec_pipe_if.slave bus
);

   logic [OPC_W-1:0] opcode_c;
   logic [XLEN-1:0]  rs1_val_c;
   logic [XLEN-1:0]  rs2_val_c;
   logic [XLEN-1:0]  imm_c;
   logic [XLEN-1:0]  opb_c;
   logic [XLEN-1:0]  alu_res_c;
   logic             alu_illegal_c;
   alu_op_e          alu_op_c;

   logic             stall_c;
   logic             accept_c;
   logic             drop_c;
   logic             opnd_err_c;
   stage_pl_t        issue_pl_c;
   logic             unused_fields_c;

   logic             stg_vld_q [LATENCY];
   logic             stg_vld_d [LATENCY];
   stage_pl_t        stg_pl_q  [LATENCY];
   stage_pl_t        stg_pl_d  [LATENCY];

   logic             fwd_vld_q, fwd_vld_d;
   stage_pl_t        fwd_pl_q,  fwd_pl_d;
   logic             err_q,     err_d;

   // Entry field extraction
   assign opcode_c  = bus.issue_entry[OPC_LSB     +: OPC_W];
   assign rs1_val_c = bus.issue_entry[RS1_VAL_LSB +: XLEN];
   assign rs2_val_c = bus.issue_entry[RS2_VAL_LSB +: XLEN];
   assign imm_c     = bus.issue_entry[IMM_LSB     +: XLEN];
   assign alu_op_c  = alu_op_e'(opcode_c[3:0]);
   assign opb_c     = opcode_c[OPC_IMM_BIT] ? imm_c : rs2_val_c;

   // Source tags and opcode[4] carry no meaning for execution
   assign unused_fields_c = ^{bus.issue_entry[PHYS_RS1_LSB +: PREG_W],
                              bus.issue_entry[PHYS_RS2_LSB +: PREG_W],
                              opcode_c[4]};

   fu_alu u_alu (
      .op        (alu_op_c),
      .a         (rs1_val_c),
      .b         (opb_c),
      .result_c  (alu_res_c),
      .illegal_c (alu_illegal_c)
   );

   always_comb begin
      issue_pl_c.rd      = bus.issue_entry[PHYS_RD_LSB +: PREG_W];
      issue_pl_c.val     = alu_res_c;
      issue_pl_c.rob_idx = bus.issue_entry[ROB_LSB +: ROB_W];
      issue_pl_c.wb_en   = ~opcode_c[OPC_NOWB_BIT];
   end

   // Handshake: a held result blocks the whole pipe; flush silently discards the issue
   assign stall_c    = fwd_vld_q & ~bus.wb_ready;
   assign accept_c   = bus.issue_enable & ~stall_c & ~bus.flush;
   assign drop_c     = bus.issue_enable &  stall_c & ~bus.flush;
   assign opnd_err_c = ~bus.issue_entry[RS1_RDY_BIT] |
                       (~bus.issue_entry[RS2_RDY_BIT] & ~opcode_c[OPC_IMM_BIT]);

   // Stage advance; output data is zeroed whenever no valid result lands
   always_comb begin
      stg_vld_d = stg_vld_q;
      stg_pl_d  = stg_pl_q;
      fwd_vld_d = fwd_vld_q;
      fwd_pl_d  = fwd_pl_q;
      if (bus.flush) begin
         for (int unsigned k = 0; k < LATENCY; k++) begin
            stg_vld_d[k] = 1'b0;
         end
         fwd_vld_d = 1'b0;
         fwd_pl_d  = '0;
      end else if (!stall_c) begin
         stg_vld_d[0] = accept_c;
         stg_pl_d[0]  = issue_pl_c;
         for (int unsigned k = 1; k < LATENCY; k++) begin
            stg_vld_d[k] = stg_vld_q[k-1];
            stg_pl_d[k]  = stg_pl_q[k-1];
         end
         fwd_vld_d = stg_vld_q[LATENCY-1];
         fwd_pl_d  = stg_vld_q[LATENCY-1] ? stg_pl_q[LATENCY-1] : '0;
      end
   end

   always_comb begin
      err_d = err_q | drop_c | (accept_c & (alu_illegal_c | opnd_err_c));
   end

   for (genvar k = 0; k < LATENCY; k++) begin : g_stage
      always_ff @(posedge clk) begin
         if (reset) begin
            stg_vld_q[k] <= 1'b0;
         end else begin
            stg_vld_q[k] <= stg_vld_d[k];
         end
      end

      always_ff @(posedge clk) begin
         stg_pl_q[k] <= stg_pl_d[k];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fwd_vld_q <= 1'b0;
         fwd_pl_q  <= '0;
         err_q     <= 1'b0;
      end else begin
         fwd_vld_q <= fwd_vld_d;
         fwd_pl_q  <= fwd_pl_d;
         err_q     <= err_d;
      end
   end

   assign bus.fu_ready    = ~stall_c;
   assign bus.fwd_valid   = fwd_vld_q;
   assign bus.fwd_rd      = fwd_pl_q.rd;
   assign bus.fwd_val     = fwd_pl_q.val;
   assign bus.fwd_rob_idx = fwd_pl_q.rob_idx;
   assign bus.fwd_wb_en   = fwd_pl_q.wb_en;
   assign bus.err_sticky  = err_q;

endmodule

// File: tb/tb_fu_exec_pipe.sv
// Scoreboard bench for fu_exec_pipe at LATENCY=2: expected results are queued at issue
// and retired against the forwarding bus on the falling edge.
module tb_fu_exec_pipe;

   typedef struct packed {
      logic [5:0]  rd;
      logic [31:0] val;
      logic [5:0]  rob;
      logic        wb_en;
   } exp_t;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_errors;
   int   hold_cnt;
   exp_t sb[$];

   fu_exec_pipe_if bus ();

   fu_exec_pipe #(.LATENCY(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
      n_checks++;
      if (got !== exp_v) begin
         n_errors++;
         $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp_v, $time);
      end
   endtask

   function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      logic [4:0] sh;
      sh = b[4:0];
      case (op)
         4'd0:    return a + b;
         4'd1:    return a - b;
         4'd2:    return a & b;
         4'd3:    return a | b;
         4'd4:    return a ^ b;
         4'd5:    return a << sh;
         4'd6:    return a >> sh;
         4'd7:    return (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
         4'd8:    return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
         4'd9:    return (a < b) ? 32'd1 : 32'd0;
         4'd10:   return b;
         default: return 32'd0;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      sb.delete();
      tick();
      reset = 1'b0;
   endtask

   // Drive one issue for a single cycle; exp_acc is the fu_ready this scenario must show
   task automatic drive_issue(input logic [6:0] opc, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] imm, input logic [5:0] rd, input logic [5:0] rob,
                              input logic r1, input logic r2, input logic [31:0] exp_val,
                              input logic exp_acc);
      exp_t e;
      bus.issue_entry  = {r2, r1, rd, 6'h2A, a, 6'h15, b, opc, imm, rob};
      bus.issue_enable = 1'b1;
      check_eq("fu_ready", 32'(bus.fu_ready), 32'(exp_acc));
      if (exp_acc && !bus.flush) begin
         e.rd    = rd;
         e.val   = exp_val;
         e.rob   = rob;
         e.wb_en = ~opc[5];
         sb.push_back(e);
      end
      tick();
      bus.issue_enable = 1'b0;
   endtask

   // Result monitor: every valid cycle must match the oldest outstanding result
   always @(negedge clk) begin
      if (bus.fwd_valid) begin
         if (sb.size() == 0) begin
            check_eq("sb_underflow", 32'(sb.size()), 32'd1);
         end else begin
            check_eq("fwd_rd",      32'(bus.fwd_rd),      32'(sb[0].rd));
            check_eq("fwd_val",     bus.fwd_val,          sb[0].val);
            check_eq("fwd_rob_idx", 32'(bus.fwd_rob_idx), 32'(sb[0].rob));
            check_eq("fwd_wb_en",   32'(bus.fwd_wb_en),   32'(sb[0].wb_en));
            if (bus.wb_ready) void'(sb.pop_front());
            else hold_cnt++;
         end
      end
   end

   initial begin
      logic [3:0]  op;
      logic [6:0]  opc;
      logic [31:0] a, b, imm;
      n_checks = 0;
      n_errors = 0;
      hold_cnt = 0;
      reset = 1'b1;
      bus.issue_enable = 1'b0;
      bus.issue_entry  = '0;
      bus.flush        = 1'b0;
      bus.wb_ready     = 1'b1;
      repeat (2) tick();

      check_eq("rst_fwd_valid", 32'(bus.fwd_valid),   32'd0);
      check_eq("rst_fwd_val",   bus.fwd_val,          32'd0);
      check_eq("rst_fwd_rd",    32'(bus.fwd_rd),      32'd0);
      check_eq("rst_fwd_rob",   32'(bus.fwd_rob_idx), 32'd0);
      check_eq("rst_fwd_wb_en", 32'(bus.fwd_wb_en),   32'd0);
      check_eq("rst_fu_ready",  32'(bus.fu_ready),    32'd1);
      check_eq("rst_err",       32'(bus.err_sticky),  32'd0);
      reset = 1'b0;

      // ADD latency: accepted at edge 0, visible after edge 2
      drive_issue(7'h00, 32'h5, 32'h7, 32'h0, 6'd10, 6'd20, 1'b1, 1'b1, 32'h0000_000C, 1'b1);
      check_eq("lat_e0_valid", 32'(bus.fwd_valid), 32'd0);
      tick();
      check_eq("lat_e1_valid", 32'(bus.fwd_valid), 32'd0);
      tick();
      check_eq("lat_e2_valid", 32'(bus.fwd_valid), 32'd1);
      check_eq("lat_e2_val",   bus.fwd_val,        32'h0000_000C);
      tick();

      // Immediate-form signed/unsigned compares and arithmetic shift, rs2 not ready is legal
      drive_issue(7'h48, 32'hFFFF_FFFE, 32'h0, 32'h1, 6'd1, 6'd1, 1'b1, 1'b0, 32'd1, 1'b1);
      drive_issue(7'h49, 32'hFFFF_FFFE, 32'h0, 32'h1, 6'd2, 6'd2, 1'b1, 1'b0, 32'd0, 1'b1);
      drive_issue(7'h47, 32'h8000_0000, 32'h0, 32'h4, 6'd3, 6'd3, 1'b1, 1'b0, 32'hF800_0000, 1'b1);
      drive_issue(7'h21, 32'h0000_0003, 32'h5, 32'h0, 6'd4, 6'd4, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b1);

      // Back-to-back random legal ops
      for (int i = 0; i < 16; i++) begin
         op  = 4'($urandom_range(0, 10));
         opc = {1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), op};
         a   = $urandom;
         b   = $urandom;
         imm = $urandom;
         drive_issue(opc, a, b, imm, 6'(i + 8), 6'(i + 30), 1'b1, 1'b1,
                     ref_alu(op, a, opc[6] ? imm : b), 1'b1);
      end
      repeat (4) tick();
      check_eq("legal_err", 32'(bus.err_sticky), 32'd0);

      // Flush with two in flight plus a same-cycle issue
      drive_issue(7'h00, 32'h1, 32'h1, 32'h0, 6'd5, 6'd5, 1'b1, 1'b1, 32'd2, 1'b1);
      drive_issue(7'h00, 32'h2, 32'h2, 32'h0, 6'd6, 6'd6, 1'b1, 1'b1, 32'd4, 1'b1);
      sb.delete();
      bus.flush = 1'b1;
      drive_issue(7'h00, 32'h3, 32'h3, 32'h0, 6'd7, 6'd7, 1'b1, 1'b1, 32'd6, 1'b1);
      bus.flush = 1'b0;
      repeat (4) tick();
      check_eq("flush_err", 32'(bus.err_sticky), 32'd0);
      drive_issue(7'h02, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h0, 6'd9, 6'd9, 1'b1, 1'b1,
                  32'h00F0_00F0, 1'b1);
      repeat (3) tick();
      check_eq("flush_sb_empty", 32'(sb.size()), 32'd0);

      // Back-pressure: three accepted, fourth dropped, head result held three cycles
      bus.wb_ready = 1'b0;
      hold_cnt = 0;
      drive_issue(7'h00, 32'd100, 32'd1, 32'h0, 6'd11, 6'd11, 1'b1, 1'b1, 32'd101, 1'b1);
      drive_issue(7'h01, 32'd100, 32'd1, 32'h0, 6'd12, 6'd12, 1'b1, 1'b1, 32'd99,  1'b1);
      drive_issue(7'h03, 32'h10,  32'h1, 32'h0, 6'd13, 6'd13, 1'b1, 1'b1, 32'h11,  1'b1);
      drive_issue(7'h00, 32'd7,   32'd7, 32'h0, 6'd14, 6'd14, 1'b1, 1'b1, 32'd14,  1'b0);
      repeat (2) tick();
      check_eq("bp_fu_ready", 32'(bus.fu_ready), 32'd0);
      bus.wb_ready = 1'b1;
      repeat (4) tick();
      check_eq("bp_hold_cycles", 32'(hold_cnt),       32'd3);
      check_eq("bp_drained",     32'(sb.size()),      32'd0);
      check_eq("bp_err",         32'(bus.err_sticky), 32'd1);
      check_eq("idle_fwd_valid", 32'(bus.fwd_valid),  32'd0);
      check_eq("idle_fwd_val",   bus.fwd_val,         32'd0);

      // Reset with two ops in flight
      drive_issue(7'h00, 32'h1, 32'h2, 32'h0, 6'd20, 6'd20, 1'b1, 1'b1, 32'd3, 1'b1);
      drive_issue(7'h00, 32'h3, 32'h4, 32'h0, 6'd21, 6'd21, 1'b1, 1'b1, 32'd7, 1'b1);
      do_reset();
      check_eq("mid_rst_fwd_valid", 32'(bus.fwd_valid),  32'd0);
      check_eq("mid_rst_fu_ready",  32'(bus.fu_ready),   32'd1);
      check_eq("mid_rst_err",       32'(bus.err_sticky), 32'd0);
      repeat (5) tick();

      // Operand not ready: still executes, error sticks through flush
      drive_issue(7'h00, 32'h40, 32'h2, 32'h0, 6'd22, 6'd22, 1'b0, 1'b1, 32'h42, 1'b1);
      repeat (3) tick();
      check_eq("opnd_err", 32'(bus.err_sticky), 32'd1);
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      repeat (3) tick();
      check_eq("opnd_err_sticks", 32'(bus.err_sticky), 32'd1);
      do_reset();
      check_eq("opnd_err_cleared", 32'(bus.err_sticky), 32'd0);

      // Illegal opcode 11: result 0, error set
      drive_issue(7'h0B, 32'h1234, 32'h5678, 32'h0, 6'd23, 6'd23, 1'b1, 1'b1, 32'd0, 1'b1);
      repeat (3) tick();
      check_eq("illegal_err", 32'(bus.err_sticky), 32'd1);

      for (int i = 0; i < 20; i++) begin
         if (sb.size() == 0) break;
         tick();
      end
      check_eq("final_sb_empty", 32'(sb.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/fu_exec_pipe.md
Name: fu_exec_pipe

Overview:
- Integer execute unit at the consumer end of the issue-queue issue port. One instance per functional unit; three instances are the default configuration.
- Accepts one issued 129-bit entry per cycle and executes an ALU micro-op in a fixed-latency pipeline.
- Drives the result onto the forwarding/writeback bus, which returns rd and value to the issue queue and ROB.
- Writeback back-pressure freezes the pipeline, and the unit reports this upstream as not-ready.

Parameters:
- LATENCY, 2, pipeline depth from issue-accept edge to result valid; legal range 1..4.
- ENTRY_SIZE, 129, width of an issued entry.
- PREG_W, 6, physical register index width.
- ROB_W, 6, ROB index width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- issue_enable  in  1  issued entry valid this cycle
- issue_entry  in  ENTRY_SIZE  issued entry
- fu_ready  out  1  unit can accept an entry this cycle
- flush  in  1  squash all in-flight ops
- wb_ready  in  1  writeback bus accepts result
- fwd_valid  out  1  result valid
- fwd_rd  out  PREG_W  destination physical register
- fwd_val  out  32  result value
- fwd_rob_idx  out  ROB_W  ROB entry to mark complete
- fwd_wb_en  out  1  result writes the register file
- err_sticky  out  1  protocol violation seen

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, sampled on the clk rising edge.
- Entry layout (LSB first):
  - rob_idx [5:0]
  - imm [37:6]
  - opcode [44:38]
  - rs2_val [76:45]
  - phys_rs2 [82:77]
  - rs1_val [114:83]
  - phys_rs1 [120:115]
  - phys_rd [126:121]
  - rs1_ready [127]
  - rs2_ready [128]
- Micro-op:
  - opcode[3:0] selects the op: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SRA=7, SLT=8, SLTU=9, PASSB=10.
  - Codes 11..15 produce result 0 and set err_sticky.
  - opcode[6]=1 makes operand B = imm; otherwise B = rs2_val.
  - opcode[5]=1 makes fwd_wb_en=0 (no register write; rd still reported).
  - Shifts use B[4:0]. SLT is signed, SLTU is unsigned.
  - All arithmetic wraps at 32 bits.
- stall = fwd_valid & ~wb_ready. fu_ready = ~stall, combinational.
- Accept: issue_enable & fu_ready. The ALU result is computed combinationally and captured into stage 1 on the accepting edge.
- Pipeline movement:
  - Each unstalled edge shifts stage k to stage k+1.
  - The final stage drives the outputs.
  - With no stall, fwd_valid rises exactly LATENCY cycles after the accepting edge.
- Stall:
  - All stages and the outputs hold.
  - fwd_* remain stable until the edge where wb_ready=1. The result is consumed on that edge.
- Back-to-back: one result per cycle at full throughput. Ordering is strictly in order.
- Violations:
  - issue_enable while fu_ready=0: the entry is dropped and err_sticky is set.
  - An accepted entry with rs1_ready=0, or with rs2_ready=0 and opcode[6]=0: the entry executes normally and err_sticky is set.
  - err_sticky clears only on reset.
- Flush:
  - Clears every stage valid bit and fwd_valid on the edge.
  - An issue in the same cycle as flush is dropped; this is not an error.
  - flush has priority over stall.
- Reset:
  - All outputs go to 0, with the exception of fu_ready, which is 1 after reset.
  - All stage valid bits clear and err_sticky clears.
  - Reset mid-operation discards in-flight ops with no output.
- Data fields in stages whose valid bit is 0 are don't-care, but the fwd_* data outputs are 0 whenever fwd_valid=0.

Decomposition:
- Package fu_pkg: ENTRY_SIZE, field bit-position localparams, micro-op enum (alu_op_e), OPC_IMM_BIT=6, OPC_NOWB_BIT=5, and a packed struct for the stage payload (rd, val, rob_idx, wb_en).
- Sub-module fu_alu: purely combinational (op, a, b) -> result plus illegal flag.
- Pipeline registers are a generate loop inside fu_exec_pipe.

Test Plan:
- ADD, LATENCY=2: accept at edge 0 with rs1_val=0x00000005, rs2_val=0x00000007, rd=10, rob=20, opcode=0x00 -> fwd_valid=1 after edge 2, fwd_val=0x0000000C, fwd_rd=10, fwd_rob_idx=20, fwd_wb_en=1.
- Immediate and signed ops: rs1_val=0xFFFFFFFE with opcode=0x48 (SLT, imm) and imm=1 -> fwd_val=1. The same inputs with opcode=0x49 (SLTU) -> fwd_val=0. opcode=0x47 (SRA) with imm=4 and rs1_val=0x80000000 -> 0xF8000000.
- Back-pressure: four back-to-back issues with wb_ready=0 from the first result onward -> fu_ready=0. The first result is held stable for 3 cycles. Raising wb_ready drains the results in order, one per cycle, with no loss. An issue attempted while fu_ready=0 sets err_sticky.
- Flush: two ops in flight plus a same-cycle issue with flush=1 -> no fwd_valid ever appears for them and err_sticky stays 0. The next issue completes normally.
- Reset mid-operation: reset=1 for one cycle with 2 ops in flight -> fwd_valid=0, fu_ready=1, err_sticky=0, and no stale results afterwards.
- Operand-not-ready: issue with rs1_ready=0 -> result still produced and err_sticky=1. Reset is the only way to clear it.
